// File: rtl/pipeline_pkg.sv
// Shared pipeline sequencing types: MUL/DIV FSM states, NOP encoding and register-match helper.
package pipeline_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  localparam logic [31:0] NOP_INSN = 32'h00000013;

  function automatic logic reg_hit(logic use_rs, logic [4:0] rs, logic [4:0] rd);
    return use_rs && (rs == rd);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
// One-cycle update latency, no backpressure.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline stall/flush sequencing for load-use, taken branch and multi-cycle MUL/DIV hazards.
// Control outputs are zero-latency combinational; the MUL/DIV freeze holds the front end until done or timeout.
module hazard_stall_controller
  import pipeline_pkg::*;
#(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs1_ID,
  input  logic [4:0]       rs2_ID,
  input  logic             use_rs1_ID,
  input  logic             use_rs2_ID,
  input  logic [4:0]       rd_EX,
  input  logic             MemRead_EX,
  input  logic             branch_taken_EX,
  input  logic             muldiv_EX,
  input  logic             md_done,
  output logic             PC_write,
  output logic             IF_ID_write,
  output logic             IF_ID_flush,
  output logic             ID_EX_write,
  output logic             ID_EX_flush,
  output logic             EX_MEM_bubble,
  output logic             md_start,
  output logic             md_error,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int TMR_W = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MD_TIMEOUT - 1);

  md_state_e        state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             md_error_q, md_error_d;
  logic             load_use;
  logic             flush_inc;
  logic             stall_inc;

  always_comb begin
    PC_write      = 1'b1;
    IF_ID_write   = 1'b1;
    IF_ID_flush   = 1'b0;
    ID_EX_write   = 1'b1;
    ID_EX_flush   = 1'b0;
    EX_MEM_bubble = 1'b0;
    md_start      = 1'b0;
    flush_inc     = 1'b0;
    state_d       = state_q;
    timer_d       = timer_q;
    md_error_d    = md_error_q;

    load_use = MemRead_EX && (rd_EX != 5'd0) &&
               (reg_hit(use_rs1_ID, rs1_ID, rd_EX) || reg_hit(use_rs2_ID, rs2_ID, rd_EX));

    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (muldiv_EX) begin
          md_start      = 1'b1;
          PC_write      = 1'b0;
          IF_ID_write   = 1'b0;
          ID_EX_write   = 1'b0;
          EX_MEM_bubble = 1'b1;
          state_d       = MD_BUSY;
        end else if (branch_taken_EX) begin
          IF_ID_flush = 1'b1;
          ID_EX_flush = 1'b1;
          flush_inc   = 1'b1;
        end else if (load_use) begin
          PC_write    = 1'b0;
          IF_ID_write = 1'b0;
          ID_EX_flush = 1'b1;
        end
      end
      MD_BUSY: begin
        PC_write      = 1'b0;
        IF_ID_write   = 1'b0;
        ID_EX_write   = 1'b0;
        EX_MEM_bubble = 1'b1;
        timer_d       = timer_q + TMR_W'(1);
        if (md_done) begin
          state_d = MD_DONE;
        end else if (timer_q == TMR_LAST) begin
          // Give up on the unit so the core keeps running; the error stays visible until reset.
          md_error_d = 1'b1;
          state_d    = MD_DONE;
        end
      end
      MD_DONE: begin
        state_d = IDLE;
        if (load_use) begin
          PC_write    = 1'b0;
          IF_ID_write = 1'b0;
          ID_EX_flush = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!rst_n) begin
      PC_write      = 1'b0;
      IF_ID_write   = 1'b0;
      IF_ID_flush   = 1'b1;
      ID_EX_write   = 1'b0;
      ID_EX_flush   = 1'b1;
      EX_MEM_bubble = 1'b1;
      md_start      = 1'b0;
      flush_inc     = 1'b0;
    end
  end

  assign stall_inc = rst_n && !PC_write;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      md_error_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      md_error_q <= md_error_d;
    end
  end

  assign md_error = md_error_q;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i   (clk),
    .clear_i (!rst_n),
    .inc_i   (stall_inc),
    .cnt_o   (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i   (clk),
    .clear_i (!rst_n),
    .inc_i   (flush_inc),
    .cnt_o   (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Bench for hazard_stall_controller: per-cycle comparison against a behavioural model
// plus directed scenarios with literal expectations.
module tb_hazard_stall_controller;

  localparam int MD_TIMEOUT = 64;
  localparam int CNT_W      = 16;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [4:0]       rs1_ID, rs2_ID, rd_EX;
  logic             use_rs1_ID, use_rs2_ID, MemRead_EX, branch_taken_EX, muldiv_EX, md_done;
  logic             PC_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_flush, EX_MEM_bubble;
  logic             md_start, md_error;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: where the MUL/DIV op is in its life, plus event tallies.
  bit m_busy, m_retire, m_err;
  int m_age, m_stall, m_flush;

  always #5 clk = ~clk;

  hazard_stall_controller #(.MD_TIMEOUT(MD_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .use_rs1_ID(use_rs1_ID), .use_rs2_ID(use_rs2_ID),
    .rd_EX(rd_EX), .MemRead_EX(MemRead_EX), .branch_taken_EX(branch_taken_EX),
    .muldiv_EX(muldiv_EX), .md_done(md_done),
    .PC_write(PC_write), .IF_ID_write(IF_ID_write), .IF_ID_flush(IF_ID_flush),
    .ID_EX_write(ID_EX_write), .ID_EX_flush(ID_EX_flush), .EX_MEM_bubble(EX_MEM_bubble),
    .md_start(md_start), .md_error(md_error), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic cmp(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic bit lu();
    return MemRead_EX && (rd_EX != 0) &&
           ((use_rs1_ID && rs1_ID == rd_EX) || (use_rs2_ID && rs2_ID == rd_EX));
  endfunction

  // Bit order {PC_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_flush, EX_MEM_bubble, md_start}
  function automatic int exp_ctrl();
    if (!rst_n)   return 7'b0010110;
    if (m_busy)   return 7'b0000010;
    if (m_retire) return lu() ? 7'b0001100 : 7'b1101000;
    if (muldiv_EX)       return 7'b0000011;
    if (branch_taken_EX) return 7'b1111100;
    if (lu())            return 7'b0001100;
    return 7'b1101000;
  endfunction

  task automatic model_update();
    int c;
    c = exp_ctrl();
    if (!rst_n) begin
      m_busy = 0; m_retire = 0; m_err = 0; m_age = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (c[6] == 1'b0 && m_stall < CNT_MAX) m_stall++;
      if (!m_busy && !m_retire && !muldiv_EX && branch_taken_EX && m_flush < CNT_MAX) m_flush++;
      if (m_busy) begin
        m_age++;
        if (md_done) begin
          m_busy = 0; m_retire = 1;
        end else if (m_age == MD_TIMEOUT) begin
          m_busy = 0; m_retire = 1; m_err = 1;
        end
      end else if (m_retire) begin
        m_retire = 0;
      end else if (muldiv_EX) begin
        m_busy = 1; m_age = 0;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    cmp("ctrl", int'({PC_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_flush,
                      EX_MEM_bubble, md_start}), exp_ctrl());
    cmp("md_error", int'(md_error), int'(m_err));
    cmp("stall_cnt", int'(stall_cnt), m_stall);
    cmp("flush_cnt", int'(flush_cnt), m_flush);
    @(posedge clk);
    #1;
    model_update();
  endtask

  task automatic idle_inputs();
    rs1_ID = 0; rs2_ID = 0; rd_EX = 0;
    use_rs1_ID = 0; use_rs2_ID = 0; MemRead_EX = 0;
    branch_taken_EX = 0; muldiv_EX = 0; md_done = 0;
  endtask

  task automatic rand_inputs();
    rs1_ID = 5'($urandom_range(0, 3));
    rs2_ID = 5'($urandom_range(0, 3));
    rd_EX  = 5'($urandom_range(0, 3));
    use_rs1_ID = 1'($urandom_range(0, 1));
    use_rs2_ID = 1'($urandom_range(0, 1));
    MemRead_EX = 1'($urandom_range(0, 1));
    branch_taken_EX = ($urandom_range(0, 4) == 0);
    muldiv_EX = ($urandom_range(0, 5) == 0);
    md_done   = ($urandom_range(0, 5) == 0);
    rst_n     = ($urandom_range(0, 63) != 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    @(posedge clk);
    #1;
    model_update();

    // Reset forcing and cleared state
    #1;
    cmp("rst_pc_write", int'(PC_write), 0);
    cmp("rst_bubble", int'(EX_MEM_bubble), 1);
    do_reset();
    cmp("rst_stall_cnt", int'(stall_cnt), 0);
    cmp("rst_md_error", int'(md_error), 0);

    // Load-use on rs1
    MemRead_EX = 1; rd_EX = 5; rs1_ID = 5; use_rs1_ID = 1;
    #1;
    cmp("lu_pc_write", int'(PC_write), 0);
    cmp("lu_if_id_write", int'(IF_ID_write), 0);
    cmp("lu_id_ex_flush", int'(ID_EX_flush), 1);
    step();
    idle_inputs();
    #1;
    cmp("lu_stall_cnt", int'(stall_cnt), 1);
    cmp("lu_cleared_pc", int'(PC_write), 1);
    step();

    // x0 destination and unused rs2 never stall
    MemRead_EX = 1; rd_EX = 0; rs1_ID = 0; use_rs1_ID = 1;
    #1;
    cmp("x0_no_stall", int'(PC_write), 1);
    step();
    idle_inputs();
    MemRead_EX = 1; rd_EX = 7; rs2_ID = 7; use_rs2_ID = 0;
    #1;
    cmp("rs2_unused_no_stall", int'(PC_write), 1);
    step();

    // Branch beats load-use
    do_reset();
    idle_inputs();
    MemRead_EX = 1; rd_EX = 5; rs1_ID = 5; use_rs1_ID = 1; branch_taken_EX = 1;
    #1;
    cmp("br_if_id_flush", int'(IF_ID_flush), 1);
    cmp("br_id_ex_flush", int'(ID_EX_flush), 1);
    cmp("br_pc_write", int'(PC_write), 1);
    step();
    idle_inputs();
    #1;
    cmp("br_flush_cnt", int'(flush_cnt), 1);
    step();

    // MUL/DIV completing on the 4th busy cycle
    do_reset();
    muldiv_EX = 1;
    #1;
    cmp("md_start_pulse", int'(md_start), 1);
    step();
    for (int i = 0; i < 4; i++) begin
      md_done = (i == 3);
      #1;
      cmp("md_busy_no_start", int'(md_start), 0);
      step();
    end
    md_done = 0;
    #1;
    cmp("md_done_pc_write", int'(PC_write), 1);
    cmp("md_done_no_restart", int'(md_start), 0);
    step();
    muldiv_EX = 0;
    #1;
    cmp("md_stall_cnt", int'(stall_cnt), 5);
    step();

    // MUL/DIV that never completes
    do_reset();
    muldiv_EX = 1;
    step();
    for (int i = 0; i < MD_TIMEOUT; i++) step();
    #1;
    cmp("to_md_error", int'(md_error), 1);
    cmp("to_resume_pc", int'(PC_write), 1);
    step();
    muldiv_EX = 0;
    step();
    do_reset();
    cmp("to_error_cleared", int'(md_error), 0);

    // Reset in the middle of a MUL/DIV
    muldiv_EX = 1;
    step();
    step();
    step();
    rst_n = 0;
    step();
    rst_n = 1;
    muldiv_EX = 0;
    #1;
    cmp("midrst_no_start", int'(md_start), 0);
    cmp("midrst_stall_cnt", int'(stall_cnt), 0);
    cmp("midrst_pc_write", int'(PC_write), 1);
    step();

    // Stall counter saturation
    idle_inputs();
    MemRead_EX = 1; rd_EX = 3; rs2_ID = 3; use_rs2_ID = 1;
    for (int i = 0; i < (1 << CNT_W) + 3; i++) step();
    idle_inputs();
    #1;
    cmp("stall_saturated", int'(stall_cnt), CNT_MAX);
    step();

    // Randomised traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
